pet_needs_fsm: RTL
==================

// Module: pet_needs_fsm
// PURPOSE
// - Downstream consumer of the debounced food/medicine buttons (b_comida/b_medicina, Boton_AR outputs).
// - Holds the pet's hunger and health levels and decays them on a timer.
// - Applies one feed/heal step per button press.
// - Derives the pet's mood state for the display/LED stages.
// PARAMETERS
// - TICK_CYCLES    50_000_000  clk cycles per base tick (1 s @ 50 MHz)
// - TEST_DIV       10          tick-period divider while test=1 (period = TICK_CYCLES/TEST_DIV)
// - LVL_MAX        5           max level for comida_lvl/salud_lvl (<=7)
// - LOW_TH         2           level <= LOW_TH counts as "low"
// - HUNGER_PERIOD  10          ticks between comida_lvl decrements
// - SICK_PERIOD    20          ticks between salud_lvl decrements
// PORTS
// - clk          in   1  system clock
// - reset        in   1  synchronous, active-high reset
// - test         in   1  accelerated-time mode
// - b_comida     in   1  debounced food button (level, active high)
// - b_medicina   in   1  debounced medicine button (level, active high)
// - comida_lvl   out  3  hunger level, 0..LVL_MAX (LVL_MAX = full)
// - salud_lvl    out  3  health level, 0..LVL_MAX
// - estado       out  2  0=FELIZ 1=HAMBRE 2=ENFERMO 3=MUERTO
// - tick         out  1  1-cycle pulse per (possibly accelerated) tick
// - ack_comida   out  1  1-cycle pulse when a food press is accepted
// - ack_medicina out  1  1-cycle pulse when a medicine press is accepted
// BEHAVIOUR
// - Single clock domain. Reset is synchronous and active-high; all state changes on posedge clk.
// - Reset values:
//   - comida_lvl = salud_lvl = LVL_MAX; estado = FELIZ.
//   - tick, ack_* = 0; prescaler and period counters = 0.
// - Buttons:
//   - Each button is registered once, then rising-edge detected against its previous registered value.
//   - One accepted press per rising edge; holding a button yields no repeats.
// - Prescaler and decay:
//   - Prescaler counts to its period-1, then wraps and pulses tick.
//   - Any change on test clears the prescaler (no partial-period carry-over).
//   - On tick, hunger and sick counters each increment.
//   - When a counter reaches its period: it clears and that level decrements, saturating at 0.
//   - If comida_lvl==0 at a hunger decrement, salud_lvl additionally decrements by 1.
// - Press effects:
//   - Food press: comida_lvl+1, saturating at LVL_MAX.
//   - Medicine press: salud_lvl+1, saturating at LVL_MAX.
//   - ack_* pulses in the same cycle the level updates.
// - Latency:
//   - Level and ack update 2 clk after the input rises.
//   - estado is registered from the levels, 1 clk later.
// - Simultaneous events:
//   - Press and decrement on the same level in one cycle: net change is 0, ack still pulses.
//   - Both buttons in one cycle: both applied.
//   - Total salud change per cycle is the algebraic sum, clamped to 0..LVL_MAX.
// - estado FSM, evaluated every cycle in priority order:
//   - salud_lvl==0 -> MUERTO
//   - salud_lvl<=LOW_TH -> ENFERMO
//   - comida_lvl<=LOW_TH -> HAMBRE
//   - else FELIZ
//   - Transitions among FELIZ, HAMBRE and ENFERMO follow the levels freely.
//   - MUERTO is terminal until reset: levels frozen, presses ignored (no ack), tick keeps running.
// - Reset asserted mid-operation overrides everything on that edge, including a press in flight.
// CONFIGURATION
// - PET_OVERFEED_EN defined:
//   - A food press with comida_lvl==LVL_MAX also decrements salud_lvl by 1 (overfeeding); ack still pulses.
// - PET_OVERFEED_EN undefined:
//   - A food press at LVL_MAX is accepted (ack pulses) with no level change.
// TESTING (TICK_CYCLES=10, TEST_DIV=5, LVL_MAX=5, LOW_TH=2, HUNGER_PERIOD=2, SICK_PERIOD=4)
// - Reset, idle 20 ticks with test=0:
//   - tick every 10 clk.
//   - comida_lvl 5->0 by tick 10; salud_lvl 5->0 by tick 12 via starvation penalty.
//   - estado FELIZ->HAMBRE->ENFERMO->MUERTO.
// - test=1:
//   - tick every 2 clk.
//   - Toggling test mid-period restarts the prescaler: next tick a full period after the toggle.
// - comida_lvl=2, hold b_comida high 50 clk:
//   - exactly one ack_comida, 2 clk after the rise.
//   - comida_lvl=3; estado HAMBRE->FELIZ 1 clk later.
// - Food press landing on the same cycle as a hunger decrement: comida_lvl unchanged, ack_comida=1.
// - At full levels, press b_comida:
//   - PET_OVERFEED_EN defined: salud_lvl 5->4.
//   - PET_OVERFEED_EN undefined: levels unchanged.
// - In MUERTO, presses -> no ack, levels 0. Pulse reset 1 clk -> levels 5, estado FELIZ next cycle.

Source files
------------

// File: rtl/pet_needs_fsm_if.sv
// ---------------------------------------------------------------------------
// pet_needs_fsm_if
//
// Purpose: bundles the button inputs and the pet status outputs of
// pet_needs_fsm so the core and its environment connect through one port.
//
// Press/ack contract: b_comida / b_medicina are level signals from the
// debouncer. A press is the rising edge of the level; the core answers each
// accepted press with exactly one single-cycle ack_* pulse, issued in the same
// cycle the corresponding level changes. There is no back-pressure: a press
// that arrives while the pet is dead is dropped without an ack, and holding a
// button high never produces a second ack.
//
// Signals:
//   test         master->slave  accelerated-time mode
//   b_comida     master->slave  debounced food button (level, active high)
//   b_medicina   master->slave  debounced medicine button (level, active high)
//   comida_lvl   slave->master  hunger level, 0..LVL_MAX (LVL_MAX = full)
//   salud_lvl    slave->master  health level, 0..LVL_MAX
//   estado       slave->master  0=FELIZ 1=HAMBRE 2=ENFERMO 3=MUERTO
//   tick         slave->master  1-cycle pulse per (possibly accelerated) tick
//   ack_comida   slave->master  1-cycle pulse per accepted food press
//   ack_medicina slave->master  1-cycle pulse per accepted medicine press
//
// Modports: master = stimulus / button side, slave = pet_needs_fsm core.
// ---------------------------------------------------------------------------
interface pet_needs_fsm_if;
  logic       test;
  logic       b_comida;
  logic       b_medicina;
  logic [2:0] comida_lvl;
  logic [2:0] salud_lvl;
  logic [1:0] estado;
  logic       tick;
  logic       ack_comida;
  logic       ack_medicina;

  modport master (
    output test,
    output b_comida,
    output b_medicina,
    input  comida_lvl,
    input  salud_lvl,
    input  estado,
    input  tick,
    input  ack_comida,
    input  ack_medicina
  );

  modport slave (
    input  test,
    input  b_comida,
    input  b_medicina,
    output comida_lvl,
    output salud_lvl,
    output estado,
    output tick,
    output ack_comida,
    output ack_medicina
  );
endinterface

// File: rtl/pet_needs_fsm.sv
// ---------------------------------------------------------------------------
// pet_needs_fsm
//
// Purpose: keeps the virtual pet's hunger (comida) and health (salud) levels,
// decays them on a timer, applies one feed / heal step per button press and
// derives the mood state (estado) for the display and LED stages.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   pet    slave modport of pet_needs_fsm_if:
//            test, b_comida, b_medicina            (inputs)
//            comida_lvl, salud_lvl, estado, tick,
//            ack_comida, ack_medicina              (outputs)
//   The estado output is the FSM state register itself.
//
// Timing:
//   button rises -> registered (1 clk) -> edge-detected, level + ack update
//   (2 clk after the rise) -> estado follows from the levels (3 clk).
//
// Configuration macro:
//   PET_OVERFEED_EN  when defined, a food press while comida_lvl is already
//                    full costs one point of health (overfeeding). When
//                    undefined, such a press is acknowledged with no change.
// ---------------------------------------------------------------------------
module pet_needs_fsm #(
  parameter int TICK_CYCLES   = 50_000_000,
  parameter int TEST_DIV      = 10,
  parameter int LVL_MAX       = 5,
  parameter int LOW_TH        = 2,
  parameter int HUNGER_PERIOD = 10,
  parameter int SICK_PERIOD   = 20
) (
  input  logic            clk,
  input  logic            reset,
  pet_needs_fsm_if.slave  pet
);

  typedef enum logic [1:0] {
    FELIZ   = 2'd0,
    HAMBRE  = 2'd1,
    ENFERMO = 2'd2,
    MUERTO  = 2'd3
  } estado_e;

  // Counter widths and terminal counts
  localparam int PW = $clog2(TICK_CYCLES + 1);
  localparam int HW = $clog2(HUNGER_PERIOD + 1);
  localparam int SW = $clog2(SICK_PERIOD + 1);

  localparam logic [PW-1:0] P_NORM_M1 = PW'(TICK_CYCLES - 1);
  localparam logic [PW-1:0] P_TEST_M1 = PW'((TICK_CYCLES / TEST_DIV) - 1);
  localparam logic [HW-1:0] H_M1      = HW'(HUNGER_PERIOD - 1);
  localparam logic [SW-1:0] S_M1      = SW'(SICK_PERIOD - 1);

  localparam logic [2:0]        LVL_MAX_3 = 3'(LVL_MAX);
  localparam logic [2:0]        LOW_TH_3  = 3'(LOW_TH);
  localparam logic signed [4:0] LVL_MAX_S = 5'(LVL_MAX);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic          btn_c_q,      btn_c_d;
  logic          btn_c_prev_q, btn_c_prev_d;
  logic          btn_m_q,      btn_m_d;
  logic          btn_m_prev_q, btn_m_prev_d;
  logic          test_q,       test_d;
  logic [PW-1:0] presc_q,      presc_d;
  logic          tick_q,       tick_d;
  logic [HW-1:0] hunger_cnt_q, hunger_cnt_d;
  logic [SW-1:0] sick_cnt_q,   sick_cnt_d;
  logic [2:0]    comida_q,     comida_d;
  logic [2:0]    salud_q,      salud_d;
  logic          ack_c_q,      ack_c_d;
  logic          ack_m_q,      ack_m_d;
  estado_e       estado_q,     estado_d;

  // -------------------------------------------------------------------------
  // Combinational intermediates
  // -------------------------------------------------------------------------
  logic                 press_c;
  logic                 press_m;
  logic                 test_chg;
  logic [PW-1:0]        period_m1;
  logic                 hunger_dec;
  logic                 sick_dec;
  logic                 starve;
  logic                 overfeed;
  logic                 dead;
  logic signed [4:0]    comida_sum;
  logic signed [4:0]    salud_sum;
  logic [2:0]           comida_new;
  logic [2:0]           salud_new;

  // -------------------------------------------------------------------------
  // Next-state logic: buttons, prescaler, decay counters, levels
  // -------------------------------------------------------------------------
  always_comb begin
    btn_c_d      = pet.b_comida;
    btn_c_prev_d = btn_c_q;
    btn_m_d      = pet.b_medicina;
    btn_m_prev_d = btn_m_q;
    test_d       = pet.test;
    presc_d      = presc_q;
    tick_d       = 1'b0;
    hunger_cnt_d = hunger_cnt_q;
    sick_cnt_d   = sick_cnt_q;
    comida_d     = comida_q;
    salud_d      = salud_q;
    ack_c_d      = 1'b0;
    ack_m_d      = 1'b0;
    hunger_dec   = 1'b0;
    sick_dec     = 1'b0;
    starve       = 1'b0;
    overfeed     = 1'b0;
    comida_new   = comida_q;
    salud_new    = salud_q;
    comida_sum   = '0;
    salud_sum    = '0;

    // One press per rising edge of the registered button level
    press_c = btn_c_q & ~btn_c_prev_q;
    press_m = btn_m_q & ~btn_m_prev_q;

    // Prescaler. A change of test restarts the period from zero so the first
    // tick in the new mode is a full new-mode period away. The >= compare
    // keeps the wrap safe even if the count ever exceeds the shorter period.
    test_chg  = (pet.test != test_q);
    period_m1 = pet.test ? P_TEST_M1 : P_NORM_M1;
    if (test_chg) begin
      presc_d = '0;
    end else if (presc_q >= period_m1) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    // Decay counters advance on the registered tick pulse
    if (tick_q) begin
      if (hunger_cnt_q >= H_M1) begin
        hunger_cnt_d = '0;
        hunger_dec   = 1'b1;
      end else begin
        hunger_cnt_d = hunger_cnt_q + 1'b1;
      end
      if (sick_cnt_q >= S_M1) begin
        sick_cnt_d = '0;
        sick_dec   = 1'b1;
      end else begin
        sick_cnt_d = sick_cnt_q + 1'b1;
      end
    end

    // Hunger: algebraic sum of press and decay, then clamp to 0..LVL_MAX.
    // A press and a decrement in the same cycle therefore cancel out.
    comida_sum = $signed({2'b00, comida_q})
               + $signed({4'b0000, press_c})
               - $signed({4'b0000, hunger_dec});
    if (comida_sum < 5'sd0) begin
      comida_new = 3'd0;
    end else if (comida_sum > LVL_MAX_S) begin
      comida_new = LVL_MAX_3;
    end else begin
      comida_new = comida_sum[2:0];
    end

    // Starvation: a hunger decrement that leaves the pet at empty also
    // costs a point of health.
    starve = hunger_dec && (comida_new == 3'd0);

`ifdef PET_OVERFEED_EN
    overfeed = press_c && (comida_q == LVL_MAX_3);
`else
    overfeed = 1'b0;
`endif

    // Health: every contribution of this cycle summed, then clamped
    salud_sum = $signed({2'b00, salud_q})
              + $signed({4'b0000, press_m})
              - $signed({4'b0000, sick_dec})
              - $signed({4'b0000, starve})
              - $signed({4'b0000, overfeed});
    if (salud_sum < 5'sd0) begin
      salud_new = 3'd0;
    end else if (salud_sum > LVL_MAX_S) begin
      salud_new = LVL_MAX_3;
    end else begin
      salud_new = salud_sum[2:0];
    end

    // Health reaching zero freezes the pet in the same cycle, so nothing
    // can revive it in the one cycle before estado registers MUERTO.
    dead = (estado_q == MUERTO) || (salud_q == 3'd0);
    if (!dead) begin
      comida_d = comida_new;
      salud_d  = salud_new;
      ack_c_d  = press_c;
      ack_m_d  = press_m;
    end
  end

  // -------------------------------------------------------------------------
  // estado FSM next state: priority decode of the registered levels,
  // MUERTO held until reset
  // -------------------------------------------------------------------------
  always_comb begin
    estado_d = estado_q;
    if (estado_q == MUERTO) begin
      estado_d = MUERTO;
    end else if (salud_q == 3'd0) begin
      estado_d = MUERTO;
    end else if (salud_q <= LOW_TH_3) begin
      estado_d = ENFERMO;
    end else if (comida_q <= LOW_TH_3) begin
      estado_d = HAMBRE;
    end else begin
      estado_d = FELIZ;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_c_q      <= 1'b0;
      btn_c_prev_q <= 1'b0;
      btn_m_q      <= 1'b0;
      btn_m_prev_q <= 1'b0;
      test_q       <= 1'b0;
      presc_q      <= '0;
      tick_q       <= 1'b0;
      hunger_cnt_q <= '0;
      sick_cnt_q   <= '0;
      comida_q     <= LVL_MAX_3;
      salud_q      <= LVL_MAX_3;
      ack_c_q      <= 1'b0;
      ack_m_q      <= 1'b0;
      estado_q     <= FELIZ;
    end else begin
      btn_c_q      <= btn_c_d;
      btn_c_prev_q <= btn_c_prev_d;
      btn_m_q      <= btn_m_d;
      btn_m_prev_q <= btn_m_prev_d;
      test_q       <= test_d;
      presc_q      <= presc_d;
      tick_q       <= tick_d;
      hunger_cnt_q <= hunger_cnt_d;
      sick_cnt_q   <= sick_cnt_d;
      comida_q     <= comida_d;
      salud_q      <= salud_d;
      ack_c_q      <= ack_c_d;
      ack_m_q      <= ack_m_d;
      estado_q     <= estado_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign pet.comida_lvl   = comida_q;
  assign pet.salud_lvl    = salud_q;
  assign pet.estado       = estado_q;
  assign pet.tick         = tick_q;
  assign pet.ack_comida   = ack_c_q;
  assign pet.ack_medicina = ack_m_q;

endmodule
